arith_unit_mc: RTL

ARITH_UNIT_MC -- requirements
Module: arith_unit_mc

---
 rtl/arith_pkg.sv | 12 +
 rtl/arith_unit_mc_div_step.sv | 19 +
 rtl/arith_unit_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared encodings for the multi-cycle arithmetic unit
package arith_pkg;
    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;
endpackage

// File: rtl/arith_unit_mc_div_step.sv
// rtl/arith_unit_mc_div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    // When the subtract succeeds the difference is below the divisor, so the low bits suffice.
    assign w_trial = w_shift[WIDTH-1:0] - i_divisor;
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_trial : w_shift[WIDTH-1:0];
endmodule

// File: rtl/arith_unit_mc.sv
// rtl/arith_unit_mc.sv - add/sub/mul in one cycle, restoring divide one bit per enabled cycle
module arith_unit_mc
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       func,
    output logic [WIDTH-1:0] arith_out,
    output logic [WIDTH-1:0] arith_hi,
    output logic             carry_out,
    output logic             div_by_zero,
    output logic             arith_flag
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_dbz;
    logic             r_flag;

    logic               w_accept;
    logic               w_div_start;
    logic               w_step_en;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem;
    logic               w_qbit;

    assign in_ready    = enable && (r_state == IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_div_start = w_accept && (func == FUNC_DIV) && (b != '0);
    assign w_step_en   = enable && (r_state == DIV);
    assign w_last      = w_step_en && (r_cnt == CW'(WIDTH - 1));
    assign w_sum       = {1'b0, a} + {1'b0, b};
    assign w_prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_div_start) w_state_nxt = DIV;
            DIV:     if (w_last)      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_out     <= '0;
            r_hi      <= '0;
            r_carry   <= 1'b0;
            r_dbz     <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            if (w_div_start) begin
                // Dividend shifts out MSB-first while quotient bits shift in at the bottom.
                r_quot    <= a;
                r_rem     <= '0;
                r_divisor <= b;
                r_cnt     <= '0;
            end else if (w_accept) begin
                r_flag <= 1'b1;
                case (func)
                    FUNC_ADD: begin
                        {r_carry, r_out} <= w_sum;
                        r_hi  <= '0;
                        r_dbz <= 1'b0;
                    end
                    FUNC_SUB: begin
                        r_out   <= a - b;
                        r_carry <= (a < b);
                        r_hi    <= '0;
                        r_dbz   <= 1'b0;
                    end
                    FUNC_MUL: begin
                        {r_hi, r_out} <= w_prod;
                        r_carry <= 1'b0;
                        r_dbz   <= 1'b0;
                    end
                    default: begin
                        r_out   <= '1;
                        r_hi    <= a;
                        r_carry <= 1'b0;
                        r_dbz   <= 1'b1;
                    end
                endcase
            end else if (w_step_en) begin
                r_quot <= {r_quot[WIDTH-2:0], w_qbit};
                r_rem  <= w_rem;
                if (w_last) begin
                    r_out   <= {r_quot[WIDTH-2:0], w_qbit};
                    r_hi    <= w_rem;
                    r_carry <= 1'b0;
                    r_dbz   <= 1'b0;
                    r_flag  <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign arith_out   = r_out;
    assign arith_hi    = r_hi;
    assign carry_out   = r_carry;
    assign div_by_zero = r_dbz;
    assign arith_flag  = r_flag;
endmodule
